// File: rtl/sync_fifo_param_pkg.sv
// Shared definitions for the parametrised synchronous FIFO.
// Purpose : default geometry constants and the occupancy-counter width helper.
// Ports   : none (package).
package sync_fifo_param_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_ADDR_W = 4;
  localparam int DEPTH      = 2 ** DEF_ADDR_W;

  // The counter must reach DEPTH itself (not DEPTH-1), hence one extra bit.
  function automatic int count_w(input int addr_w);
    return $clog2((2 ** addr_w) + 1);
  endfunction

endpackage

// File: rtl/sync_fifo_param_if.sv
// Bus interface of the parametrised synchronous FIFO.
// Purpose : bundles push/pop handshake, data, status and error signals.
// Modports: master - producer/consumer side (drives wr/rd/w_data/flush/clr_err)
//           slave  - FIFO side (drives r_data, r_valid, count and all flags)
interface sync_fifo_param_if
  import sync_fifo_param_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
);

  localparam int CNT_W = count_w(ADDR_W);

  logic              flush;
  logic              wr;
  logic [DATA_W-1:0] w_data;
  logic              rd;
  logic              clr_err;
  logic [DATA_W-1:0] r_data;
  logic              r_valid;
  logic              full;
  logic              empty;
  logic              almost_full;
  logic              almost_empty;
  logic [CNT_W-1:0]  count;
  logic              overflow;
  logic              underflow;

  modport master (
    output flush, wr, w_data, rd, clr_err,
    input  r_data, r_valid, full, empty, almost_full, almost_empty,
           count, overflow, underflow
  );

  modport slave (
    input  flush, wr, w_data, rd, clr_err,
    output r_data, r_valid, full, empty, almost_full, almost_empty,
           count, overflow, underflow
  );

endinterface

// File: rtl/sync_fifo_param_mem.sv
// fifo_mem - dual-port storage for the synchronous FIFO.
// Purpose : synchronous write port; read port is either combinational
//           (show-ahead) or a registered BRAM-style read loaded on rd_en_i.
// Ports   : clk, rst_n (resets only the read register),
//           wr_en_i/wr_addr_i/wr_data_i  write port,
//           rd_en_i/rd_addr_i/rd_data_o  read port.
module fifo_mem #(
  parameter int DATA_W  = 8,
  parameter int ADDR_W  = 4,
  parameter int OUT_REG = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic              rd_en_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic [DATA_W-1:0] rd_data_o
);

  // Storage is deliberately not reset so it can map onto block RAM.
  logic [DATA_W-1:0] mem_q [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  generate
    if (OUT_REG != 0) begin : g_reg_read
      logic [DATA_W-1:0] rd_data_q;

      // Holds the last popped word until the next accepted pop.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          rd_data_q <= '0;
        end else if (rd_en_i) begin
          rd_data_q <= mem_q[rd_addr_i];
        end
      end

      assign rd_data_o = rd_data_q;
    end else begin : g_comb_read
      logic unused_ok;
      assign unused_ok = &{1'b0, rst_n, rd_en_i};
      assign rd_data_o = mem_q[rd_addr_i];
    end
  endgenerate

endmodule

// File: rtl/sync_fifo_param.sv
// sync_fifo_param - parametrised single-clock FIFO.
// Purpose : pointers, occupancy count, registered status flags, sticky
//           overflow/underflow errors and synchronous flush around fifo_mem.
// Ports   : clk   - system clock, rising edge
//           rst_n - asynchronous active-low reset
//           bus   - sync_fifo_param_if.slave (handshake, data, status, errors)
module sync_fifo_param
  import sync_fifo_param_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int AF_THRESH = 14,
  parameter int AE_THRESH = 2,
  parameter int OUT_REG   = 0
) (
  input  logic clk,
  input  logic rst_n,
  sync_fifo_param_if.slave bus
);

  localparam int CNT_W      = count_w(ADDR_W);
  localparam int FIFO_DEPTH = 2 ** ADDR_W;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] AF_C    = CNT_W'(AF_THRESH);
  localparam logic [CNT_W-1:0] AE_C    = CNT_W'(AE_THRESH);

  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic full_q, full_d, empty_q, empty_d;
  logic afull_q, afull_d, aempty_q, aempty_d;
  logic ovf_q, ovf_d, udf_q, udf_d;
  logic push_ok, pop_ok;

  always_comb begin
    // Accept decisions use last cycle's registered flags only; flush
    // suppresses both so nothing is stored, popped or flagged alongside it.
    push_ok  = bus.wr & ~full_q & ~bus.flush;
    pop_ok   = bus.rd & ~empty_q & ~bus.flush;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;

    if (bus.flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end

    full_d   = (count_d == DEPTH_C);
    empty_d  = (count_d == '0);
    afull_d  = (count_d >= AF_C);
    aempty_d = (count_d <= AE_C);

    // Set term is ORed after the clear so a same-cycle set wins.
    ovf_d = (bus.wr & full_q & ~bus.flush) | (ovf_q & ~bus.clr_err);
    udf_d = (bus.rd & empty_q & ~bus.flush) | (udf_q & ~bus.clr_err);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      afull_q  <= 1'b0;
      aempty_q <= 1'b1;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      afull_q  <= afull_d;
      aempty_q <= aempty_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  fifo_mem #(
    .DATA_W  (DATA_W),
    .ADDR_W  (ADDR_W),
    .OUT_REG (OUT_REG)
  ) u_mem (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en_i   (push_ok),
    .wr_addr_i (wr_ptr_q),
    .wr_data_i (bus.w_data),
    .rd_en_i   (pop_ok),
    .rd_addr_i (rd_ptr_q),
    .rd_data_o (bus.r_data)
  );

  generate
    if (OUT_REG != 0) begin : g_valid_reg
      logic r_valid_q;
      // High only in the cycle after an accepted pop; flush masks pop_ok.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_valid_q <= 1'b0;
        else        r_valid_q <= pop_ok;
      end
      assign bus.r_valid = r_valid_q;
    end else begin : g_valid_comb
      assign bus.r_valid = ~empty_q;
    end
  endgenerate

  assign bus.count        = count_q;
  assign bus.full         = full_q;
  assign bus.empty        = empty_q;
  assign bus.almost_full  = afull_q;
  assign bus.almost_empty = aempty_q;
  assign bus.overflow     = ovf_q;
  assign bus.underflow    = udf_q;

endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed bench: drives one show-ahead (OUT_REG=0) and one registered-read
// (OUT_REG=1) FIFO with identical stimulus and checks both.
module tb_sync_fifo_param;

  logic clk;
  logic rst_n;
  logic flush, wr, rd, clr_err;
  logic [7:0] w_data;
  int n_checks;
  int n_fail;

  sync_fifo_param_if #(.DATA_W(8), .ADDR_W(4)) if0 ();
  sync_fifo_param_if #(.DATA_W(8), .ADDR_W(4)) if1 ();

  assign if0.flush = flush;   assign if1.flush = flush;
  assign if0.wr = wr;         assign if1.wr = wr;
  assign if0.rd = rd;         assign if1.rd = rd;
  assign if0.w_data = w_data; assign if1.w_data = w_data;
  assign if0.clr_err = clr_err; assign if1.clr_err = clr_err;

  sync_fifo_param #(.DATA_W(8), .ADDR_W(4), .AF_THRESH(14), .AE_THRESH(2), .OUT_REG(0))
    u_dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));
  sync_fifo_param #(.DATA_W(8), .ADDR_W(4), .AF_THRESH(14), .AE_THRESH(2), .OUT_REG(1))
    u_dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b1; flush = 0; wr = 0; rd = 0; clr_err = 0; w_data = 8'h00;
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (if0.count !== 5'd0 || if1.count !== 5'd0 || if0.empty !== 1'b1 || if1.empty !== 1'b1 ||
        if0.almost_empty !== 1'b1 || if1.almost_empty !== 1'b1 || if0.full !== 1'b0 || if1.full !== 1'b0 ||
        if0.almost_full !== 1'b0 || if1.almost_full !== 1'b0 || if0.overflow !== 1'b0 || if1.overflow !== 1'b0 ||
        if0.underflow !== 1'b0 || if1.underflow !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_status: cnt0=%0d cnt1=%0d e=%b%b ae=%b%b f=%b%b af=%b%b ovf=%b%b udf=%b%b required cnt=0 e=1 ae=1 f=0 af=0 ovf=0 udf=0",
               if0.count, if1.count, if0.empty, if1.empty, if0.almost_empty, if1.almost_empty,
               if0.full, if1.full, if0.almost_full, if1.almost_full, if0.overflow, if1.overflow,
               if0.underflow, if1.underflow);
    end
    n_checks++;
    if (if0.r_valid !== 1'b0 || if1.r_valid !== 1'b0 || if1.r_data !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_rdata: rv0=%b rv1=%b rdata1=%h required rv=0 rdata1=00", if0.r_valid, if1.r_valid, if1.r_data);
    end
    step(); step();
    #3 rst_n = 1'b1;
    step();
    $display("reset done");
  endtask

  task automatic test_fill_drain();
    for (int i = 0; i < 16; i++) begin
      wr = 1; w_data = 8'(i);
      step();
      $display("push %h", 8'(i));
      n_checks++;
      if (if0.count !== 5'(i + 1) || if1.count !== 5'(i + 1) ||
          if0.almost_empty !== (i + 1 <= 2) || if1.almost_empty !== (i + 1 <= 2) ||
          if0.almost_full !== (i + 1 >= 14) || if1.almost_full !== (i + 1 >= 14) ||
          if0.full !== (i + 1 == 16) || if1.full !== (i + 1 == 16) || if0.empty !== 1'b0) begin
        n_fail++;
        $display("FAIL fill_flags[%0d]: cnt=%0d/%0d ae=%b af=%b f=%b e=%b required cnt=%0d ae=%b af=%b f=%b e=0",
                 i, if0.count, if1.count, if0.almost_empty, if0.almost_full, if0.full, if0.empty,
                 i + 1, (i + 1 <= 2), (i + 1 >= 14), (i + 1 == 16));
      end
      if (i == 0) begin
        n_checks++;
        if (if0.r_valid !== 1'b1 || if0.r_data !== 8'h00 || if1.r_valid !== 1'b0) begin
          n_fail++;
          $display("FAIL show_ahead_first: rv0=%b rdata0=%h rv1=%b required rv0=1 rdata0=00 rv1=0",
                   if0.r_valid, if0.r_data, if1.r_valid);
        end
      end
    end
    wr = 0;
    for (int i = 0; i < 16; i++) begin
      rd = 1;
      #1;
      n_checks++;
      if (if0.r_data !== 8'(i)) begin
        n_fail++;
        $display("FAIL drain_head0[%0d]: got %h required %h", i, if0.r_data, 8'(i));
      end
      step();
      $display("pop %h", 8'(i));
      n_checks++;
      if (if1.r_valid !== 1'b1 || if1.r_data !== 8'(i) || if0.count !== 5'(15 - i) || if1.count !== 5'(15 - i)) begin
        n_fail++;
        $display("FAIL drain_reg1[%0d]: rv=%b rdata=%h cnt=%0d/%0d required rv=1 rdata=%h cnt=%0d",
                 i, if1.r_valid, if1.r_data, if0.count, if1.count, 8'(i), 15 - i);
      end
    end
    rd = 0;
    step();
    n_checks++;
    if (if0.empty !== 1'b1 || if1.empty !== 1'b1 || if0.r_valid !== 1'b0 || if1.r_valid !== 1'b0 ||
        if1.r_data !== 8'h0F) begin
      n_fail++;
      $display("FAIL drain_end: e=%b%b rv=%b%b rdata1=%h required e=1 rv=0 rdata1=0f",
               if0.empty, if1.empty, if0.r_valid, if1.r_valid, if1.r_data);
    end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 16; i++) begin
      wr = 1; w_data = 8'h20 + 8'(i);
      step();
    end
    w_data = 8'hAA;
    step();
    $display("push aa while full");
    n_checks++;
    if (if0.count !== 5'd16 || if1.count !== 5'd16 || if0.overflow !== 1'b1 || if1.overflow !== 1'b1) begin
      n_fail++;
      $display("FAIL overflow_set: cnt=%0d/%0d ovf=%b%b required cnt=16 ovf=1", if0.count, if1.count, if0.overflow, if1.overflow);
    end
    clr_err = 1;
    step();
    n_checks++;
    if (if0.overflow !== 1'b1 || if1.overflow !== 1'b1) begin
      n_fail++;
      $display("FAIL overflow_set_wins: ovf=%b%b required 1", if0.overflow, if1.overflow);
    end
    wr = 0;
    step();
    clr_err = 0;
    n_checks++;
    if (if0.overflow !== 1'b0 || if1.overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL overflow_clear: ovf=%b%b required 0", if0.overflow, if1.overflow);
    end
    for (int i = 0; i < 16; i++) begin
      rd = 1;
      #1;
      n_checks++;
      if (if0.r_data !== 8'h20 + 8'(i)) begin
        n_fail++;
        $display("FAIL ovf_drain0[%0d]: got %h required %h", i, if0.r_data, 8'h20 + 8'(i));
      end
      step();
      n_checks++;
      if (if1.r_data !== 8'h20 + 8'(i)) begin
        n_fail++;
        $display("FAIL ovf_drain1[%0d]: got %h required %h", i, if1.r_data, 8'h20 + 8'(i));
      end
    end
    rd = 0;
    step();
    n_checks++;
    if (if0.empty !== 1'b1 || if1.empty !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_drain_empty: e=%b%b required 1", if0.empty, if1.empty);
    end
  endtask

  task automatic test_underflow();
    rd = 1;
    step();
    rd = 0;
    $display("pop while empty");
    n_checks++;
    if (if0.underflow !== 1'b1 || if1.underflow !== 1'b1 || if0.count !== 5'd0 || if1.count !== 5'd0) begin
      n_fail++;
      $display("FAIL underflow_set: udf=%b%b cnt=%0d/%0d required udf=1 cnt=0", if0.underflow, if1.underflow, if0.count, if1.count);
    end
    wr = 1; rd = 1; w_data = 8'h55;
    step();
    wr = 0; rd = 0;
    $display("push 55 + pop on empty");
    n_checks++;
    if (if0.count !== 5'd1 || if1.count !== 5'd1 || if0.r_data !== 8'h55 || if0.r_valid !== 1'b1 || if1.r_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL wr_rd_empty: cnt=%0d/%0d rdata0=%h rv0=%b rv1=%b required cnt=1 rdata0=55 rv0=1 rv1=0",
               if0.count, if1.count, if0.r_data, if0.r_valid, if1.r_valid);
    end
    rd = 1; clr_err = 1;
    step();
    rd = 0; clr_err = 0;
    n_checks++;
    if (if1.r_valid !== 1'b1 || if1.r_data !== 8'h55 || if0.underflow !== 1'b0 || if1.underflow !== 1'b0 || if0.empty !== 1'b1) begin
      n_fail++;
      $display("FAIL pop_55: rv1=%b rdata1=%h udf=%b%b e0=%b required rv1=1 rdata1=55 udf=0 e0=1",
               if1.r_valid, if1.r_data, if0.underflow, if1.underflow, if0.empty);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 8; i++) begin
      wr = 1; w_data = 8'h40 + 8'(i);
      step();
    end
    rd = 1;
    for (int k = 0; k < 20; k++) begin
      w_data = 8'h48 + 8'(k);
      #1;
      n_checks++;
      if (if0.r_data !== 8'h40 + 8'(k)) begin
        n_fail++;
        $display("FAIL b2b_head0[%0d]: got %h required %h", k, if0.r_data, 8'h40 + 8'(k));
      end
      step();
      $display("push %h pop %h", 8'h48 + 8'(k), 8'h40 + 8'(k));
      n_checks++;
      if (if0.count !== 5'd8 || if1.count !== 5'd8 || if1.r_data !== 8'h40 + 8'(k) || if1.r_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL b2b[%0d]: cnt=%0d/%0d rdata1=%h rv1=%b required cnt=8 rdata1=%h rv1=1",
                 k, if0.count, if1.count, if1.r_data, if1.r_valid, 8'h40 + 8'(k));
      end
    end
    wr = 0;
    for (int i = 0; i < 8; i++) begin
      #1;
      n_checks++;
      if (if0.r_data !== 8'h54 + 8'(i)) begin
        n_fail++;
        $display("FAIL b2b_drain0[%0d]: got %h required %h", i, if0.r_data, 8'h54 + 8'(i));
      end
      step();
      n_checks++;
      if (if1.r_data !== 8'h54 + 8'(i)) begin
        n_fail++;
        $display("FAIL b2b_drain1[%0d]: got %h required %h", i, if1.r_data, 8'h54 + 8'(i));
      end
    end
    rd = 0;
    step();
  endtask

  task automatic test_flush();
    for (int i = 0; i < 17; i++) begin
      wr = 1; w_data = 8'h60 + 8'(i);
      step();
    end
    wr = 0; rd = 1;
    for (int i = 0; i < 6; i++) begin
      step();
      n_checks++;
      if (if1.r_data !== 8'h60 + 8'(i)) begin
        n_fail++;
        $display("FAIL flush_pre_pop[%0d]: got %h required %h", i, if1.r_data, 8'h60 + 8'(i));
      end
    end
    rd = 0;
    flush = 1; wr = 1; w_data = 8'h77;
    step();
    flush = 0; wr = 0;
    $display("flush with push 77");
    n_checks++;
    if (if0.count !== 5'd0 || if1.count !== 5'd0 || if0.empty !== 1'b1 || if1.empty !== 1'b1 ||
        if0.almost_empty !== 1'b1 || if0.full !== 1'b0 || if0.overflow !== 1'b1 || if1.overflow !== 1'b1 ||
        if0.r_valid !== 1'b0 || if1.r_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_state: cnt=%0d/%0d e=%b%b ae=%b f=%b ovf=%b%b rv=%b%b required cnt=0 e=1 ae=1 f=0 ovf=1 rv=0",
               if0.count, if1.count, if0.empty, if1.empty, if0.almost_empty, if0.full,
               if0.overflow, if1.overflow, if0.r_valid, if1.r_valid);
    end
    wr = 1; w_data = 8'h88;
    step();
    wr = 0; rd = 1;
    #1;
    n_checks++;
    if (if0.r_data !== 8'h88 || if0.count !== 5'd1) begin
      n_fail++;
      $display("FAIL flush_after_push: rdata0=%h cnt=%0d required rdata0=88 cnt=1", if0.r_data, if0.count);
    end
    clr_err = 1;
    step();
    rd = 0; clr_err = 0;
    n_checks++;
    if (if1.r_data !== 8'h88 || if0.empty !== 1'b1 || if0.overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_after_pop: rdata1=%h e0=%b ovf=%b required rdata1=88 e0=1 ovf=0", if1.r_data, if0.empty, if0.overflow);
    end
  endtask

  task automatic test_reg_read_async_reset();
    rd = 1;
    step();
    rd = 0;
    for (int i = 0; i < 3; i++) begin
      wr = 1; w_data = 8'h90 + 8'(i);
      step();
    end
    wr = 0; rd = 1;
    step();
    rd = 0;
    n_checks++;
    if (if1.r_valid !== 1'b1 || if1.r_data !== 8'h90) begin
      n_fail++;
      $display("FAIL reg_pop_n1: rv1=%b rdata1=%h required rv1=1 rdata1=90", if1.r_valid, if1.r_data);
    end
    step();
    n_checks++;
    if (if1.r_valid !== 1'b0 || if1.r_data !== 8'h90 || if0.r_data !== 8'h91 || if0.count !== 5'd2) begin
      n_fail++;
      $display("FAIL reg_pop_n2: rv1=%b rdata1=%h rdata0=%h cnt=%0d required rv1=0 rdata1=90 rdata0=91 cnt=2",
               if1.r_valid, if1.r_data, if0.r_data, if0.count);
    end
    wr = 1; rd = 1; w_data = 8'hA0;
    step();
    step();
    #2 rst_n = 1'b0;
    #1;
    $display("async reset mid-burst");
    n_checks++;
    if (if0.count !== 5'd0 || if1.count !== 5'd0 || if0.empty !== 1'b1 || if1.empty !== 1'b1 ||
        if0.underflow !== 1'b0 || if1.underflow !== 1'b0 || if0.r_valid !== 1'b0 || if1.r_valid !== 1'b0 ||
        if1.r_data !== 8'h00 || if0.almost_empty !== 1'b1 || if0.full !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset: cnt=%0d/%0d e=%b%b udf=%b%b rv=%b%b rdata1=%h ae=%b f=%b required cnt=0 e=1 udf=0 rv=0 rdata1=00 ae=1 f=0",
               if0.count, if1.count, if0.empty, if1.empty, if0.underflow, if1.underflow,
               if0.r_valid, if1.r_valid, if1.r_data, if0.almost_empty, if0.full);
    end
    wr = 0; rd = 0;
    #2 rst_n = 1'b1;
    step();
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    test_reset();
    test_fill_drain();
    test_overflow();
    test_underflow();
    test_back_to_back();
    test_flush();
    test_reg_read_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sync_fifo_param.md
Name: sync_fifo_param

Overview:
Parametrised synchronous FIFO. It is the generalised successor of the team's fixed 8-bit × 16 FIFO.
- Adds configurable width and depth, an occupancy count, and programmable almost-full and almost-empty flags.
- Adds sticky overflow and underflow error flags, and a synchronous flush.
- Offers a selectable read mode: show-ahead (combinational) or registered (BRAM-style).
- Sits between producer/consumer blocks in the same clock domain, e.g. UART RX/TX buffering and command queues.

Parameters:
- DATA_W, 8, data word width in bits.
- ADDR_W, 4, address width; DEPTH = 2**ADDR_W entries.
- AF_THRESH, 14, almost_full asserts when count >= AF_THRESH (1..DEPTH).
- AE_THRESH, 2, almost_empty asserts when count <= AE_THRESH (0..DEPTH-1).
- OUT_REG, 0, read mode: 0 = show-ahead combinational read, 1 = registered read with 1-cycle latency.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- flush  input  1  synchronous clear of pointers, count and flags.
- wr  input  1  push request.
- w_data  input  DATA_W  write data.
- rd  input  1  pop request.
- r_data  output  DATA_W  read data.
- r_valid  output  1  r_data valid (see Behaviour).
- full  output  1  count == DEPTH.
- empty  output  1  count == 0.
- almost_full  output  1  count >= AF_THRESH.
- almost_empty  output  1  count <= AE_THRESH.
- count  output  ADDR_W+1  current occupancy, 0..DEPTH.
- overflow  output  1  sticky: a write was attempted while full.
- underflow  output  1  sticky: a read was attempted while empty.
- clr_err  input  1  clears overflow/underflow.

Behaviour:
- One clock domain. Reset is asynchronous and active-low.
- Reset values:
  - pointers = 0, count = 0;
  - empty = 1, almost_empty = 1;
  - full = 0, almost_full = 0;
  - overflow = 0, underflow = 0;
  - r_valid = 0, r_data = 0 when OUT_REG=1.
  - Memory contents are not reset.
- Accept rules:
  - push_ok = wr & ~full.
  - pop_ok = rd & ~empty.
  - Evaluated on the registered flags of the current cycle.
- Simultaneous wr and rd:
  - Not full and not empty: both accepted; count unchanged; both pointers advance.
  - Full: pop only; the write is dropped and overflow is set.
  - Empty: push only; the read is ignored and underflow is set.
- Pointers are ADDR_W bits and wrap naturally from DEPTH-1 to 0.
- count is updated +1 on push-only, -1 on pop-only, 0 otherwise.
- All status flags are registered and derived from count_next, so they are valid in the cycle after the causing edge. No combinational path exists from wr/rd to any flag.
- Error flags: overflow is set on wr & full; underflow on rd & empty. Both hold until clr_err. If set and clear occur in the same cycle, set wins.
- flush:
  - Has priority over wr/rd; a same-cycle wr/rd is ignored and not flagged.
  - Restores pointers, count, full/empty/almost flags and r_valid to reset values.
  - Does not clear overflow/underflow or the memory.
- OUT_REG=0:
  - r_data = mem[r_ptr] combinationally; r_valid = ~empty.
  - A word written at edge N is visible on r_data from cycle N+1 if the FIFO was empty.
  - pop_ok advances r_ptr at the edge; the next word appears the following cycle.
- OUT_REG=1:
  - On pop_ok at edge N, r_data is loaded with mem[r_ptr] at edge N and r_valid=1 for exactly that following cycle.
  - r_data holds its last value otherwise; r_valid=0 when no pop was accepted.
- Write-to-read: there is no read of an address being written in the same cycle, because pops from an empty FIFO are rejected.
- Asserting rst_n low mid-operation immediately forces reset values. Stored data is considered lost.

Decomposition:
- Shared package/header fifo_defs:
  - default DATA_W/ADDR_W constants;
  - a count-width function clog2-based (ADDR_W+1);
  - localparam DEPTH.
- Sub-module fifo_mem: dual-port storage with parameters DATA_W, ADDR_W, OUT_REG.
  - Synchronous write on wr_en.
  - Combinational read, or registered read with rd_en.
- Control, count, flags and error logic live in sync_fifo_param.

Test Plan (DATA_W=8, ADDR_W=4, AF=14, AE=2, both OUT_REG values):
1. Reset, then 16 pushes 0x00..0x0F:
   - count 1..16;
   - almost_empty drops when count reaches 3;
   - almost_full rises at 14;
   - full=1 after the 16th push.
   Then 16 pops return 0x00..0x0F in order; empty=1 at the end.
2. Full FIFO, wr=1 with 0xAA:
   - count stays 16;
   - overflow=1 next cycle;
   - 0xAA is never read back.
   Then clr_err pulse -> overflow=0.
3. Empty FIFO, rd=1 -> underflow=1, count 0. Same-cycle wr=1/rd=1 with 0x55 on an empty FIFO -> count 1, r_data 0x55 (OUT_REG=0).
4. Half-full (8 entries), wr and rd together for 20 cycles:
   - count stays 8;
   - pointers wrap past 15;
   - data stays in order.
5. Flush with 10 entries and wr=1 in the same cycle:
   - count 0, empty=1 next cycle;
   - the write is not stored;
   - the sticky overflow set beforehand remains 1.
6. OUT_REG=1: a pop at edge N -> r_valid=1 only in cycle N+1 with the correct word. rst_n pulsed low mid-burst -> all outputs reset asynchronously, before the next clock edge.
